// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Computes MUL/MULH/MULHSU/MULHU with a
// 32-cycle shift-add loop and DIV/DIVU/REM/REMU with a 32-cycle restoring
// shift-subtract loop on operand magnitudes. The result sign is applied when
// the last iteration completes. Divide-by-zero and signed overflow bypass the
// loop and finish one edge after the request is accepted.
//
// Build option:
//   RV32M_FAST_MUL_EN - when defined, all multiplies use a combinational
//                       33x33 signed multiplier and finish one edge after
//                       acceptance; divides stay iterative.
// -----------------------------------------------------------------------------
module muldiv_unit (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iRs1Data,
    input  logic [31:0] iRs2Data,
    input  logic [4:0]  iRd,
    output logic        oBusy,
    output logic        oDone,
    output logic        oRegWrite,
    output logic [4:0]  oRd,
    output logic [31:0] oResult
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_n;
    logic [4:0]  counter_r;
    logic [2:0]  funct3_r;
    logic [4:0]  rd_r;
    logic [31:0] a_r;       // multiplicand, or dividend shifted out MSB first
    logic [31:0] b_r;       // multiplier shifted out LSB first, or divisor
    logic        neg_r;     // negate the final magnitude
    logic [63:0] acc_r;     // product, or {remainder, quotient}

    // Request decode (operands as presented in IDLE)
    logic        is_div_s;
    logic        is_rem_s;
    logic        sign_a_en_s;
    logic        sign_b_en_s;
    logic        sign_a_s;
    logic        sign_b_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        neg_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic        special_s;
    logic [31:0] special_result_s;

    // Iteration datapath
    logic [32:0] mul_sum_s;
    logic [63:0] mul_acc_s;
    logic [32:0] rem_shift_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_acc_s;
    logic [63:0] acc_next_s;
    logic [63:0] prod_final_s;
    logic [31:0] quot_final_s;
    logic [31:0] rem_final_s;
    logic [31:0] calc_result_s;

`ifdef RV32M_FAST_MUL_EN
    logic [63:0] fast_a_s;
    logic [63:0] fast_b_s;
    logic [63:0] fast_prod_s;
`endif

    // Decode the incoming request: signedness, magnitudes and special cases
    always_comb begin
        is_div_s    = iFunct3[2];
        is_rem_s    = iFunct3[2] & iFunct3[1];
        sign_a_en_s = is_div_s ? ~iFunct3[0] : (iFunct3[1:0] != 2'b11);
        sign_b_en_s = is_div_s ? ~iFunct3[0] : ~iFunct3[1];
        sign_a_s    = sign_a_en_s & iRs1Data[31];
        sign_b_s    = sign_b_en_s & iRs2Data[31];
        mag_a_s     = sign_a_s ? (~iRs1Data + 32'd1) : iRs1Data;
        mag_b_s     = sign_b_s ? (~iRs2Data + 32'd1) : iRs2Data;
        neg_s       = is_rem_s ? sign_a_s : (sign_a_s ^ sign_b_s);
        div_zero_s  = is_div_s & (iRs2Data == 32'd0);
        div_ovf_s   = is_div_s & ~iFunct3[0] & (iRs1Data == 32'h8000_0000) &
                      (iRs2Data == 32'hFFFF_FFFF);
        special_s        = div_zero_s | div_ovf_s;
        special_result_s = 32'd0;
        if (div_zero_s) begin
            special_result_s = is_rem_s ? iRs1Data : 32'hFFFF_FFFF;
        end else if (div_ovf_s) begin
            special_result_s = is_rem_s ? 32'd0 : 32'h8000_0000;
        end else begin
            special_result_s = 32'd0;
        end
`ifdef RV32M_FAST_MUL_EN
        // 33-bit signed operands, sign-extended; the low 64 bits of the
        // product are exact for every signedness combination.
        fast_a_s    = {{32{sign_a_en_s & iRs1Data[31]}}, iRs1Data};
        fast_b_s    = {{32{sign_b_en_s & iRs2Data[31]}}, iRs2Data};
        fast_prod_s = fast_a_s * fast_b_s;
        if (!is_div_s) begin
            special_s        = 1'b1;
            special_result_s = (iFunct3[1:0] == 2'b00) ? fast_prod_s[31:0]
                                                       : fast_prod_s[63:32];
        end else begin
            special_s        = div_zero_s | div_ovf_s;
        end
`endif
    end

    // One shift-add or restoring shift-subtract step and final sign/selection
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[63:32]} + (b_r[0] ? {1'b0, a_r} : 33'd0);
        mul_acc_s   = {mul_sum_s, acc_r[31:1]};
        rem_shift_s = {acc_r[63:32], a_r[31]};
        div_diff_s  = rem_shift_s - {1'b0, b_r};
        if (div_diff_s[32]) begin
            div_acc_s = {rem_shift_s[31:0], acc_r[30:0], 1'b0};
        end else begin
            div_acc_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
        end
        acc_next_s   = funct3_r[2] ? div_acc_s : mul_acc_s;
        prod_final_s = neg_r ? (~acc_next_s + 64'd1) : acc_next_s;
        quot_final_s = neg_r ? (~acc_next_s[31:0] + 32'd1) : acc_next_s[31:0];
        rem_final_s  = neg_r ? (~acc_next_s[63:32] + 32'd1) : acc_next_s[63:32];
        case (funct3_r)
            3'b000:  calc_result_s = prod_final_s[31:0];
            3'b001,
            3'b010,
            3'b011:  calc_result_s = prod_final_s[63:32];
            3'b100,
            3'b101:  calc_result_s = quot_final_s;
            3'b110,
            3'b111:  calc_result_s = rem_final_s;
            default: calc_result_s = 32'd0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (iStart) begin
                    state_n = special_s ? DONE : CALC;
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                if (counter_r == 5'd0) begin
                    state_n = DONE;
                end else begin
                    state_n = CALC;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, operand latches, iteration state and result/rd outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_r   <= IDLE;
            counter_r <= 5'd0;
            funct3_r  <= 3'd0;
            rd_r      <= 5'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            neg_r     <= 1'b0;
            acc_r     <= 64'd0;
            oRd       <= 5'd0;
            oResult   <= 32'd0;
        end else begin
            state_r <= state_n;
            case (state_r)
                IDLE: begin
                    if (iStart && special_s) begin
                        oResult <= special_result_s;
                        oRd     <= iRd;
                    end else if (iStart) begin
                        funct3_r  <= iFunct3;
                        rd_r      <= iRd;
                        a_r       <= mag_a_s;
                        b_r       <= mag_b_s;
                        neg_r     <= neg_s;
                        acc_r     <= 64'd0;
                        counter_r <= 5'd31;
                    end
                end
                CALC: begin
                    acc_r <= acc_next_s;
                    if (funct3_r[2]) begin
                        a_r <= {a_r[30:0], 1'b0};
                    end else begin
                        b_r <= {1'b0, b_r[31:1]};
                    end
                    if (counter_r == 5'd0) begin
                        oResult <= calc_result_s;
                        oRd     <= rd_r;
                    end else begin
                        counter_r <= counter_r - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oBusy     = (state_r != IDLE);
    assign oDone     = (state_r == DONE);
    assign oRegWrite = (state_r == DONE) && (oRd != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed vectors, randomized operations
// against a 64-bit arithmetic reference, busy/ignore and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        iCLK;
    logic        iRST;
    logic        iStart;
    logic [2:0]  iFunct3;
    logic [31:0] iRs1Data;
    logic [31:0] iRs2Data;
    logic [4:0]  iRd;
    logic        oBusy;
    logic        oDone;
    logic        oRegWrite;
    logic [4:0]  oRd;
    logic [31:0] oResult;

    int tests_run;
    int tests_failed;

    muldiv_unit dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iStart    (iStart),
        .iFunct3   (iFunct3),
        .iRs1Data  (iRs1Data),
        .iRs2Data  (iRs2Data),
        .iRd       (iRd),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oRegWrite (oRegWrite),
        .oRd       (oRd),
        .oResult   (oResult)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Reference: RV32M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Reference: edges from accept to DONE entry
    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 0;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef RV32M_FAST_MUL_EN
        if (!f3[2]) return 0;
`endif
        return 32;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation, wait for completion and check everything visible
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input string name);
        int lat;
        int exp_lat;
        exp_lat = ref_latency(f3, a, b);
        @(negedge iCLK);
        iFunct3 = f3; iRs1Data = a; iRs2Data = b; iRd = rd; iStart = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iFunct3 = 3'($urandom); iRs1Data = $urandom; iRs2Data = $urandom; iRd = 5'($urandom);
        tests_run++;
        if (oBusy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, oBusy);
        end
        lat = 0;
        while (oDone !== 1'b1 && lat < 100) begin
            @(posedge iCLK);
            #1;
            lat++;
        end
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (oResult !== exp_res) begin
            tests_failed++;
            $display("FAIL %s result: got %h want %h", name, oResult, exp_res);
        end
        tests_run++;
        if (oRd !== rd) begin
            tests_failed++;
            $display("FAIL %s rd: got %0d want %0d", name, oRd, rd);
        end
        tests_run++;
        if (oRegWrite !== (rd != 5'd0)) begin
            tests_failed++;
            $display("FAIL %s regwrite: got %b want %b", name, oRegWrite, (rd != 5'd0));
        end
        @(posedge iCLK);
        #1;
        tests_run++;
        if ({oDone, oRegWrite, oBusy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s pulse_end: got done/we/busy=%b want 000", name,
                     {oDone, oRegWrite, oBusy});
        end
        tests_run++;
        if (oResult !== exp_res) begin
            tests_failed++;
            $display("FAIL %s result_hold: got %h want %h", name, oResult, exp_res);
        end
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({oBusy, oDone, oRegWrite, oRd, oResult} !== 40'd0) begin
            tests_failed++;
            $display("FAIL %s: got busy=%b done=%b we=%b rd=%0d res=%h want all 0",
                     name, oBusy, oDone, oRegWrite, oRd, oResult);
        end
    endtask

    task automatic test_reset();
        iRST = 1'b1; iStart = 1'b0; iFunct3 = 3'd0;
        iRs1Data = 32'd0; iRs2Data = 32'd0; iRd = 5'd0;
        #1;
        check_all_zero("reset_async");
        repeat (2) @(posedge iCLK);
        #1;
        check_all_zero("reset_held");
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, "mul_7_m3");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, "mulh_min");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, "mulhu_max");
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, "mulhsu_max");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, "rem_m7_2");
        run_op(3'd5, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC, "divu_m7_2");
        run_op(3'd7, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'd1,         "remu_m7_2");
        run_op(3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, "divu_by0");
        run_op(3'd6, 32'd5,          32'd0,         5'd10, 32'd5,         "rem_by0");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         "rem_ovf");
        run_op(3'd0, 32'd3,          32'd4,         5'd0,  32'd12,        "mul_rd0");
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom);
            run_op(f3, a, b, rd, ref_result(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
        end
    endtask

    // Second request while busy is dropped; first result is unaffected
    task automatic test_busy_ignore();
        int edges;
        bit idle_ok;
        @(negedge iCLK);
        iFunct3 = 3'd4; iRs1Data = 32'd100; iRs2Data = 32'd7; iRd = 5'd12; iStart = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        edges = 0;
        repeat (4) begin
            @(posedge iCLK);
            #1;
            edges++;
        end
        @(negedge iCLK);
        iFunct3 = 3'd0; iRs1Data = 32'd3; iRs2Data = 32'd3; iRd = 5'd9; iStart = 1'b1;
        @(posedge iCLK);
        #1;
        edges++;
        iStart = 1'b0;
        while (oDone !== 1'b1 && edges < 100) begin
            @(posedge iCLK);
            #1;
            edges++;
        end
        tests_run++;
        if (edges !== 32) begin
            tests_failed++;
            $display("FAIL busy_ignore latency: got %0d want 32", edges);
        end
        tests_run++;
        if (oResult !== 32'd14 || oRd !== 5'd12) begin
            tests_failed++;
            $display("FAIL busy_ignore result: got %h rd %0d want 0000000e rd 12", oResult, oRd);
        end
        idle_ok = 1'b1;
        repeat (40) begin
            @(posedge iCLK);
            #1;
            if (oBusy !== 1'b0 || oDone !== 1'b0) idle_ok = 1'b0;
        end
        tests_run++;
        if (!idle_ok) begin
            tests_failed++;
            $display("FAIL busy_ignore no_queue: got activity after drop want idle");
        end
    endtask

    // Reset mid-calculation aborts without write-back; next op runs normally
    task automatic test_reset_abort();
        bit quiet;
        @(negedge iCLK);
        iFunct3 = 3'd5; iRs1Data = 32'd1000; iRs2Data = 32'd3; iRd = 5'd17; iStart = 1'b1;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        repeat (9) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        #1;
        check_all_zero("abort_async");
        @(negedge iCLK);
        iRST = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge iCLK);
            #1;
            if (oDone !== 1'b0 || oBusy !== 1'b0 || oRegWrite !== 1'b0) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet) begin
            tests_failed++;
            $display("FAIL abort_no_done: got activity after reset want none");
        end
        run_op(3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'd1,          "b2b_mul");
        run_op(3'd7, 32'd17,        32'd5,         5'd21, 32'd2,          "b2b_remu");
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3,         5'd22, 32'hFFFF_FFFF,  "b2b_mulh");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle/multicycle datapath. It consumes the two register-file read ports as operands, computes one of the eight M-extension operations over 32 iterations, and returns a one-cycle write-back request (result, destination register, write enable) to the register file's write port. The control unit stalls the PC while oBusy is high.

## Interface
- No parameters; width fixed at 32 bits, iteration count fixed at 32.
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iStart  in  1  request; sampled only in IDLE.
- iFunct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- iRs1Data  in  32  operand A (dividend / multiplicand), from read port 1.
- iRs2Data  in  32  operand B (divisor / multiplier), from read port 2.
- iRd  in  5  destination register index.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle completion pulse.
- oRegWrite  out  1  equals oDone AND (oRd != 0); drives the register-file write enable.
- oRd  out  5  latched destination index.
- oResult  out  32  result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC on iStart. Latch funct3, rd, |A|, |B| and the result-sign flags; clear the 64-bit accumulator; set counter = 31.
- IDLE -> DONE directly (special cases, result latched at the same edge):
  - DIV/DIVU with B = 0: quotient 0xFFFFFFFF.
  - REM/REMU with B = 0: result = A.
  - DIV with A = 0x80000000, B = 0xFFFFFFFF: result 0x80000000; REM of the same operands: result 0.
- CALC, multiply: shift-add, one multiplier bit per cycle; 64-bit product.
- CALC, divide: restoring shift-subtract, one quotient bit per cycle.
- CALC -> DONE at the edge where counter = 0; otherwise counter decrements.
- DONE -> IDLE unconditionally after one cycle. oDone = 1 in DONE only.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Magnitudes are computed on absolute values, then negated in two's complement at the CALC -> DONE edge.
  - Product sign = signA XOR signB. Quotient sign = signA XOR signB. Remainder sign = signA.
- Result selection: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32]; DIV/DIVU take the quotient; REM/REMU take the remainder.
- iStart in CALC or DONE is ignored; no queuing. The operation is dropped; the controller must hold iStart until oBusy is low.
- Operand and funct3 inputs are don't-care after the accept edge.

## Timing
- Reset (async, any state, including mid-CALC): state IDLE, counter 0, oBusy 0, oDone 0, oRegWrite 0, oRd 0, oResult 0. An aborted operation produces no write-back.
- Iterative latency: start accepted at edge k; DONE entered at edge k+32; oDone high during cycle k+32..k+33; register file written at edge k+33.
- Special-case latency: DONE entered at edge k; oDone high during cycle k..k+1.
- oBusy rises at edge k and falls at the edge leaving DONE. A new start is accepted at the first edge with state = IDLE.
- oResult and oRd change only on entering DONE (or on reset).

## Configuration
- RV32M_FAST_MUL_EN:
  - Defined: MUL, MULH, MULHSU and MULHU use a combinational 33x33 signed multiplier and take the special-case path (IDLE -> DONE at edge k, latency 1). Divide remains iterative.
  - Undefined: all multiplies use the 32-iteration path.

## Test plan
- MUL, A = 7, B = 0xFFFFFFFD, rd = 5: oResult 0xFFFFFFEB, oRd 5, oRegWrite 1 for one cycle, 32 edges after accept (0 with RV32M_FAST_MUL_EN).
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide, A = 0xFFFFFFF9 (-7), B = 2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU -> 0x7FFFFFFC; REMU -> 1.
- Special cases, done one edge after accept:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Busy and reset:
  - Pulse iStart with DIV 100/7, then pulse iStart again at cycle 5: the second request is ignored; result 14.
  - Assert iRST at cycle 10 of a new operation: all outputs 0 immediately, no oDone; the next start runs normally.
- rd = 0, MUL 3 x 4: oDone 1, oResult 12, oRegWrite 0.
